uart_fifo_gen: RTL

//  Parametrised full-duplex UART; next generation of the two-byte-buffered uart.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_fifo_gen.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state types and helpers for the uart_fifo_gen UART.
package uart_pkg;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NINTH = 2'b11;

    localparam int unsigned STATUS_W    = 5;
    localparam int unsigned ST_NOISE    = 0;
    localparam int unsigned ST_FRAME    = 1;
    localparam int unsigned ST_PARITY   = 2;
    localparam int unsigned ST_OVERRUN  = 3;
    localparam int unsigned ST_NINTH    = 4;

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxPar, RxStop, RxBreak
    } rx_state_e;

    typedef enum logic [2:0] {
        TxIdle, TxStart, TxData, TxPar, TxStop1, TxStop2
    } tx_state_e;

    // Bit sent in the parity slot; data_xor is the XOR of all data bits.
    function automatic logic tx_parity(input logic [1:0] mode, input logic data_xor,
                                       input logic ninth);
        case (mode)
            PAR_ODD:   return ~data_xor;
            PAR_EVEN:  return data_xor;
            PAR_NINTH: return ninth;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO; pointers carry an extra wrap bit.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [W-1:0]                   wdata_i,
    output logic [W-1:0]                   rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    assign level_o = LW'(wptr_q - rptr_q);

endmodule

// File: rtl/uart_fifo_gen.sv
// Full-duplex UART with RX/TX FIFOs, 3-sample majority receive, parity and loopback.
// RX and TX each run their own baud counter; both FIFOs are first-word fall-through.
module uart_fifo_gen
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned BAUD_W   = 16
) (
    input  logic                             clk,
    input  logic                             nreset,
    input  logic                             rxd,
    output logic                             txd,
    input  logic [BAUD_W-1:0]                baudrate,
    input  logic [7:0]                       control,
    input  logic [DATA_W-1:0]                txdata,
    input  logic                             write_tx,
    output logic                             tx_full,
    output logic                             tx_empty,
    output logic [$clog2(TX_DEPTH+1)-1:0]    tx_level,
    output logic [DATA_W-1:0]                rxdata,
    output logic [STATUS_W-1:0]              rx_status,
    output logic                             rx_valid,
    input  logic                             read_rx,
    output logic [$clog2(RX_DEPTH+1)-1:0]    rx_level
);
    localparam int unsigned RXW = DATA_W + STATUS_W;

    logic [1:0] par_mode;
    logic       two_stop, discard, rx_en, loopback, tx_en, ninth_tx;
    assign par_mode = control[1:0];
    assign two_stop = control[2];
    assign discard  = control[3];
    assign rx_en    = control[4];
    assign loopback = control[5];
    assign tx_en    = control[6];
    assign ninth_tx = control[7];

    logic [BAUD_W-1:0] mid, mid_m1, mid_p1;
    assign mid    = baudrate >> 1;
    assign mid_m1 = mid - BAUD_W'(1);
    assign mid_p1 = mid + BAUD_W'(1);

    logic rxd_meta_q, rxd_sync_q, txd_q, txd_d;

    // ---------------- RX ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_s0_q, rx_s0_d, rx_s1_q, rx_s1_d;
    logic              rx_noise_q, rx_noise_d, rx_perr_q, rx_perr_d;
    logic              rx_ninth_q, rx_ninth_d, rx_ovr_q, rx_ovr_d;
    logic              rx_line, rx_maj, rx_dis, rx_decide, rx_bit_end, rx_bad;
    logic              rx_push, rx_full, rx_empty;
    logic [STATUS_W-1:0] rx_stat;
    logic [RXW-1:0]    rx_wdata, rx_rdata;

    assign rx_line    = loopback ? txd_q : rxd_sync_q;
    assign rx_maj     = (rx_s0_q & rx_s1_q) | (rx_s0_q & rx_line) | (rx_s1_q & rx_line);
    assign rx_dis     = !((rx_s0_q == rx_s1_q) && (rx_s1_q == rx_line));
    assign rx_decide  = (rx_cnt_q == mid_p1);
    assign rx_bit_end = (rx_cnt_q == baudrate);
    assign rx_wdata   = {rx_stat, rx_shift_q};

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_s0_d    = rx_s0_q;
        rx_s1_d    = rx_s1_q;
        rx_noise_d = rx_noise_q;
        rx_perr_d  = rx_perr_q;
        rx_ninth_d = rx_ninth_q;
        rx_ovr_d   = rx_ovr_q;
        rx_push    = 1'b0;
        rx_stat    = '0;
        rx_bad     = 1'b0;
        if (rx_state_q inside {RxStart, RxData, RxPar, RxStop}) begin
            rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + BAUD_W'(1);
            if (rx_cnt_q == mid_m1) rx_s0_d = rx_line;
            if (rx_cnt_q == mid)    rx_s1_d = rx_line;
        end
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_en && !rx_line) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_noise_d = 1'b0;
                    rx_perr_d  = 1'b0;
                    rx_ninth_d = 1'b0;
                end
            end
            RxStart: begin
                if (rx_decide) begin
                    rx_noise_d = rx_dis;
                    if (rx_maj) rx_state_d = RxIdle;
                end
                if (rx_bit_end) rx_state_d = RxData;
            end
            RxData: begin
                if (rx_decide) begin
                    rx_shift_d = {rx_maj, rx_shift_q[DATA_W-1:1]};
                    rx_noise_d = rx_noise_q | rx_dis;
                end
                if (rx_bit_end) begin
                    rx_bit_d = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'(DATA_W - 1)) begin
                        rx_state_d = (par_mode == PAR_NONE) ? RxStop : RxPar;
                    end
                end
            end
            RxPar: begin
                if (rx_decide) begin
                    rx_noise_d = rx_noise_q | rx_dis;
                    if (par_mode == PAR_NINTH) rx_ninth_d = rx_maj;
                    else rx_perr_d = (^{rx_shift_q, rx_maj}) != (par_mode == PAR_ODD);
                end
                if (rx_bit_end) rx_state_d = RxStop;
            end
            RxStop: begin
                // Decide mid-stop so the following start edge is never missed.
                if (rx_decide) begin
                    rx_stat[ST_NOISE]   = rx_noise_q | rx_dis;
                    rx_stat[ST_FRAME]   = !rx_maj;
                    rx_stat[ST_PARITY]  = rx_perr_q;
                    rx_stat[ST_OVERRUN] = rx_ovr_q;
                    rx_stat[ST_NINTH]   = rx_ninth_q;
                    rx_bad = rx_stat[ST_NOISE] | rx_stat[ST_FRAME] | rx_stat[ST_PARITY];
                    if (!(discard && rx_bad)) begin
                        if (rx_full && !read_rx) begin
                            rx_ovr_d = 1'b1;
                        end else begin
                            rx_push  = 1'b1;
                            rx_ovr_d = 1'b0;
                        end
                    end
                    rx_state_d = rx_maj ? RxIdle : RxBreak;
                end
            end
            RxBreak: begin
                if (rx_line) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    uart_sync_fifo #(
        .W     (RXW),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .push_i  (rx_push),
        .pop_i   (read_rx),
        .wdata_i (rx_wdata),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    assign rxdata    = rx_rdata[DATA_W-1:0];
    assign rx_status = rx_rdata[DATA_W +: STATUS_W];
    assign rx_valid  = !rx_empty;

    // ---------------- TX ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d, tx_head;
    logic              tx_par_q, tx_par_d;
    logic              tx_pop, tx_next, tx_fifo_empty, tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == baudrate);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_next    = 1'b0;
        txd_d      = 1'b1;
        if (tx_state_q != TxIdle) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + BAUD_W'(1);
        unique case (tx_state_q)
            TxIdle:  tx_next = 1'b1;
            TxStart: begin
                txd_d = 1'b0;
                if (tx_bit_end) begin
                    tx_state_d = TxData;
                    tx_bit_d   = '0;
                end
            end
            TxData: begin
                txd_d = tx_shift_q[0];
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'(DATA_W - 1)) begin
                        tx_state_d = (par_mode == PAR_NONE) ? TxStop1 : TxPar;
                    end
                end
            end
            TxPar: begin
                txd_d = tx_par_q;
                if (tx_bit_end) tx_state_d = TxStop1;
            end
            TxStop1: begin
                if (tx_bit_end) begin
                    if (two_stop) tx_state_d = TxStop2;
                    else tx_next = 1'b1;
                end
            end
            TxStop2: begin
                if (tx_bit_end) tx_next = 1'b1;
            end
            default: tx_state_d = TxIdle;
        endcase
        // Reloading straight from the last stop bit gives back-to-back frames.
        if (tx_next) begin
            if (tx_en && !tx_fifo_empty) begin
                tx_pop     = 1'b1;
                tx_state_d = TxStart;
                tx_cnt_d   = '0;
                tx_shift_d = tx_head;
                tx_par_d   = tx_parity(par_mode, ^tx_head, ninth_tx);
            end else begin
                tx_state_d = TxIdle;
            end
        end
    end

    uart_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .push_i  (write_tx),
        .pop_i   (tx_pop),
        .wdata_i (txdata),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_fifo_empty),
        .level_o (tx_level)
    );

    assign tx_empty = tx_fifo_empty && (tx_state_q == TxIdle);
    assign txd      = txd_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            txd_q      <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s0_q    <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_noise_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ninth_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s0_q    <= rx_s0_d;
            rx_s1_q    <= rx_s1_d;
            rx_noise_q <= rx_noise_d;
            rx_perr_q  <= rx_perr_d;
            rx_ninth_q <= rx_ninth_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
        end
    end

endmodule
